// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational output decode: state plus the few qualifying inputs map to
// every datapath strobe and select.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  input  logic       zero,
  input  logic [5:0] opcode,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal_op
);

  always_comb begin
    alu_op     = ALUOP_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    pc_src     = PCSRC_ALU;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal_op = 1'b0;
    case (state_t'(state))
      S_FETCH: begin
        // IR load and PC+4 commit only on the cycle the read completes
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_IMM_SH2;
        illegal_op = !is_legal(opcode);
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_write  = zero;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control sequencer: state register, next-state logic and
// retired-instruction counter; outputs come from mips_ctrl_decode.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [1:0]       alu_op,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  always_comb begin
    state_d = S_START;
    case (state_q)
      S_START:  state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
      default:  state_d = S_START;
    endcase
  end

  // Illegal-opcode returns leave from DECODE, so they are excluded here
  assign retire = (state_d == S_FETCH) &&
                  (state_q inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH,
                                   S_ADDIWB, S_JUMP});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_START;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

  mips_ctrl_decode u_decode (
    .state      (state_q),
    .mem_ready  (mem_ready),
    .zero       (zero),
    .opcode     (opcode),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .iord       (iord),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .illegal_op (illegal_op)
  );

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Cycle-accurate vector bench for the multi-cycle control sequencer.
module tb_mips_multicycle_control;

  localparam int CNT_W = 4;

  localparam logic [3:0] ST_START = 4'd0,  ST_FETCH = 4'd1,  ST_DECODE = 4'd2;
  localparam logic [3:0] ST_MEMADR = 4'd3, ST_MEMRD = 4'd4,  ST_MEMWB = 4'd5;
  localparam logic [3:0] ST_MEMWR = 4'd6,  ST_EXEC = 4'd7,   ST_ALUWB = 4'd8;
  localparam logic [3:0] ST_BRANCH = 4'd9, ST_ADDIEX = 4'd10, ST_ADDIWB = 4'd11;
  localparam logic [3:0] ST_JUMP = 4'd12;

  // {alu_op, src_a, src_b, pc_src, pc_write, ir_write, mem_read, mem_write,
  //  iord, reg_write, reg_dst, mem_to_reg, illegal_op}
  localparam logic [15:0] C_ZERO  = 16'b00_0_00_00_0_0_0_0_0_0_0_0_0;
  localparam logic [15:0] C_FRDY  = 16'b00_0_01_00_1_1_1_0_0_0_0_0_0;
  localparam logic [15:0] C_FWAIT = 16'b00_0_01_00_0_0_1_0_0_0_0_0_0;
  localparam logic [15:0] C_DEC   = 16'b00_0_11_00_0_0_0_0_0_0_0_0_0;
  localparam logic [15:0] C_DILL  = 16'b00_0_11_00_0_0_0_0_0_0_0_0_1;
  localparam logic [15:0] C_IMMEX = 16'b00_1_10_00_0_0_0_0_0_0_0_0_0;
  localparam logic [15:0] C_MEMRD = 16'b00_0_00_00_0_0_1_0_1_0_0_0_0;
  localparam logic [15:0] C_MEMWB = 16'b00_0_00_00_0_0_0_0_0_1_0_1_0;
  localparam logic [15:0] C_MEMWR = 16'b00_0_00_00_0_0_0_1_1_0_0_0_0;
  localparam logic [15:0] C_EXEC  = 16'b10_1_00_00_0_0_0_0_0_0_0_0_0;
  localparam logic [15:0] C_ALUWB = 16'b00_0_00_00_0_0_0_0_0_1_1_0_0;
  localparam logic [15:0] C_BR_T  = 16'b01_1_00_01_1_0_0_0_0_0_0_0_0;
  localparam logic [15:0] C_BR_N  = 16'b01_1_00_01_0_0_0_0_0_0_0_0_0;
  localparam logic [15:0] C_ADDWB = 16'b00_0_00_00_0_0_0_0_0_1_0_0_0;
  localparam logic [15:0] C_JUMP  = 16'b00_0_00_10_1_0_0_0_0_0_0_0_0;

  typedef struct {
    logic [5:0]       op;
    logic             z;
    logic             mr;
    logic [3:0]       st;
    logic [15:0]      ctrl;
    logic [CNT_W-1:0] ret;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic zero = 1'b0, mem_ready = 1'b1;
  logic [1:0] alu_op, alu_src_b, pc_src;
  logic alu_src_a, pc_write, ir_write, mem_read, mem_write, iord;
  logic reg_write, reg_dst, mem_to_reg, illegal_op;
  logic [3:0] state;
  logic [CNT_W-1:0] retired;
  logic [15:0] ctrl;

  int n_cmp = 0, n_bad = 0;
  vec_t vecs[$];
  vec_t sb[$];
  int row_id = 0;

  always #5 clk = ~clk;

  mips_multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .alu_op(alu_op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_write(pc_write),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal_op(illegal_op), .state(state),
    .retired(retired)
  );

  assign ctrl = {alu_op, alu_src_a, alu_src_b, pc_src, pc_write, ir_write,
                 mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg,
                 illegal_op};

  task automatic check(input string name, input int row,
                       input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, got, want);
    end
  endtask

  function automatic void add(input logic [5:0] op, input logic z,
                              input logic mr, input logic [3:0] st,
                              input logic [15:0] c, input logic [CNT_W-1:0] r);
    vec_t v;
    v.op = op; v.z = z; v.mr = mr; v.st = st; v.ctrl = c; v.ret = r;
    vecs.push_back(v);
  endfunction

  // Scoreboard consumer: one expected record per cycle, checked mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      vec_t e;
      e = sb.pop_front();
      check("state",   row_id, 32'(state),   32'(e.st));
      check("ctrl",    row_id, 32'(ctrl),    32'(e.ctrl));
      check("retired", row_id, 32'(retired), 32'(e.ret));
      row_id++;
    end
  end

  task automatic drive(input vec_t v);
    opcode = v.op; zero = v.z; mem_ready = v.mr;
    sb.push_back(v);
  endtask

  initial begin
    logic [CNT_W-1:0] r;

    // R-type out of reset
    add(6'd0,  0, 1, ST_START,  C_ZERO,  0);
    add(6'd0,  0, 1, ST_FETCH,  C_FRDY,  0);
    add(6'd0,  0, 1, ST_DECODE, C_DEC,   0);
    add(6'd0,  0, 1, ST_EXEC,   C_EXEC,  0);
    add(6'd0,  0, 1, ST_ALUWB,  C_ALUWB, 0);
    // lw with three wait cycles in MEMRD
    add(6'd35, 0, 1, ST_FETCH,  C_FRDY,  1);
    add(6'd35, 0, 0, ST_DECODE, C_DEC,   1);
    add(6'd35, 0, 1, ST_MEMADR, C_IMMEX, 1);
    add(6'd35, 0, 0, ST_MEMRD,  C_MEMRD, 1);
    add(6'd35, 1, 0, ST_MEMRD,  C_MEMRD, 1);
    add(6'd35, 0, 0, ST_MEMRD,  C_MEMRD, 1);
    add(6'd35, 0, 1, ST_MEMRD,  C_MEMRD, 1);
    add(6'd35, 0, 0, ST_MEMWB,  C_MEMWB, 1);
    // sw with one fetch wait
    add(6'd43, 0, 0, ST_FETCH,  C_FWAIT, 2);
    add(6'd43, 0, 1, ST_FETCH,  C_FRDY,  2);
    add(6'd43, 0, 1, ST_DECODE, C_DEC,   2);
    add(6'd43, 0, 0, ST_MEMADR, C_IMMEX, 2);
    add(6'd43, 0, 1, ST_MEMWR,  C_MEMWR, 2);
    // beq taken, then not taken
    add(6'd4,  1, 1, ST_FETCH,  C_FRDY,  3);
    add(6'd4,  0, 1, ST_DECODE, C_DEC,   3);
    add(6'd4,  1, 0, ST_BRANCH, C_BR_T,  3);
    add(6'd4,  1, 1, ST_FETCH,  C_FRDY,  4);
    add(6'd4,  1, 1, ST_DECODE, C_DEC,   4);
    add(6'd4,  0, 1, ST_BRANCH, C_BR_N,  4);
    // addi
    add(6'd8,  0, 1, ST_FETCH,  C_FRDY,  5);
    add(6'd8,  0, 1, ST_DECODE, C_DEC,   5);
    add(6'd8,  0, 0, ST_ADDIEX, C_IMMEX, 5);
    add(6'd8,  0, 1, ST_ADDIWB, C_ADDWB, 5);
    // illegal opcodes do not retire
    add(6'd63, 0, 1, ST_FETCH,  C_FRDY,  6);
    add(6'd63, 0, 1, ST_DECODE, C_DILL,  6);
    add(6'd1,  0, 1, ST_FETCH,  C_FRDY,  6);
    add(6'd1,  0, 1, ST_DECODE, C_DILL,  6);
    // 16 jumps wrap the 4-bit counter through 15 -> 0
    r = CNT_W'(6);
    for (int k = 0; k < 16; k++) begin
      add(6'd2, 0, 1, ST_FETCH,  C_FRDY, r);
      add(6'd2, 0, 0, ST_DECODE, C_DEC,  r);
      add(6'd2, k[0], 0, ST_JUMP, C_JUMP, r);
      r = r + CNT_W'(1);
    end
    // sw parked in MEMWR for the async reset case
    add(6'd43, 0, 1, ST_FETCH,  C_FRDY,  r);
    add(6'd43, 0, 1, ST_DECODE, C_DEC,   r);
    add(6'd43, 0, 1, ST_MEMADR, C_IMMEX, r);
    add(6'd43, 0, 0, ST_MEMWR,  C_MEMWR, r);

    // Reset state while held
    #12;
    check("reset_state",   -1, 32'(state),   32'(ST_START));
    check("reset_ctrl",    -1, 32'(ctrl),    32'(C_ZERO));
    check("reset_retired", -1, 32'(retired), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      if (i == vecs.size() - 1) break;
      @(posedge clk); #1;
    end

    // Drop reset between edges while waiting in MEMWR
    @(negedge clk); #2;
    check("pre_rst_mem_write", -2, 32'(mem_write), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_state",     -2, 32'(state),     32'(ST_START));
    check("async_rst_mem_write", -2, 32'(mem_write), 0);
    check("async_rst_ctrl",      -2, 32'(ctrl),      32'(C_ZERO));
    check("async_rst_retired",   -2, 32'(retired),   0);
    @(posedge clk); #1;
    check("held_rst_state",      -2, 32'(state),     32'(ST_START));
    check("sb_drained",          -2, 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
